debug_view: RTL and testbench
=============================

DEBUG_VIEW -- requirements
Module: debug_view

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable samples before a button level is accepted.
REQ-002 Parameter REFRESH_CYCLES, default 5000000, period of automatic re-read of the displayed word.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for rd_ack.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_inc  input  1  raw button, step address up.
REQ-007 btn_dec  input  1  raw button, step address down.
REQ-008 btn_mode  input  1  raw button, toggle view source.
REQ-009 rd_req  output  1  read request to debug read port.
REQ-010 rd_sel  output  1  source select: 0 = register file, 1 = data memory.
REQ-011 rd_addr  output  8  read address.
REQ-012 rd_ack  input  1  read data valid, one-cycle pulse.
REQ-013 rd_data  input  32  read data, valid when rd_ack = 1.
REQ-014 data_display  output  32  word driven to the 8-digit hex display.
REQ-015 addr_led  output  8  current view address.
REQ-016 mode_led  output  1  current view source (mirrors mode register).

Function
REQ-017 Each button passes a 2-flop synchronizer, then a debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-018 A 0->1 transition of a debounced level produces a one-cycle event pulse; holding a button produces exactly one event.
REQ-019 Mode event: mode toggles, address set to 0, read pending set.
REQ-020 Inc event: register mode wraps 31->0 (addr[7:5] stay 0); memory mode wraps 255->0; read pending set.
REQ-021 Dec event: register mode wraps 0->31; memory mode wraps 0->255; read pending set.
REQ-022 Inc and dec events in the same cycle: address unchanged, no pending set.
REQ-023 Mode event coincident with inc/dec: mode event wins, address = 0.
REQ-024 Refresh counter counts 0..REFRESH_CYCLES-1 and sets read pending on wrap.
REQ-025 FSM states IDLE, WAIT.
REQ-026 IDLE with pending = 1: next cycle rd_req = 1, rd_addr/rd_sel latched from address/mode, pending cleared, state WAIT.
REQ-027 WAIT: rd_req, rd_addr, rd_sel held stable; address/mode events still update internal registers and set pending but do not alter latched rd_addr/rd_sel.
REQ-028 WAIT with rd_ack = 1: data_display <= rd_data same edge, rd_req = 0 next cycle, state IDLE.
REQ-029 WAIT without rd_ack for TIMEOUT_CYCLES cycles: data_display <= 32'hFFFF_FFFF, rd_req = 0, state IDLE.
REQ-030 rd_ack while IDLE is ignored.
REQ-031 Pending set during WAIT issues a new request on the second cycle after returning to IDLE (back-to-back, one IDLE cycle minimum).
REQ-032 addr_led and mode_led reflect internal registers immediately, not latched request values.

Reset
REQ-033 On rst = 1, asynchronously: rd_req = 0, rd_sel = 0, rd_addr = 0, data_display = 0, address = 0, mode = 0, state IDLE, debounced levels 0, all counters 0.
REQ-034 pending = 1 on reset, so the first read (reg 0) is issued immediately after reset release.
REQ-035 Reset asserted during WAIT drops rd_req without waiting for the clock edge; a late rd_ack after release is ignored.

Verification (DEBOUNCE_CYCLES=4, REFRESH_CYCLES=64, TIMEOUT_CYCLES=8)
REQ-036 Release reset, ack after 3 cycles with rd_data=32'h1234_5678 -> rd_addr=0, rd_sel=0, data_display=32'h1234_5678, rd_req low next cycle.
REQ-037 btn_inc glitch 2 cycles high -> no event; held 20 cycles -> exactly one event, addr_led=1, one read at rd_addr=1.
REQ-038 Register mode at addr 0, dec press -> addr_led=31; in memory mode at 255, inc press -> addr_led=0.
REQ-039 Never assert rd_ack -> rd_req high exactly 8 cycles, then data_display=32'hFFFF_FFFF, state IDLE.
REQ-040 Inc press during WAIT at addr 3 -> rd_addr stays 3 until ack, then new request at rd_addr=4.
REQ-041 Mode press from addr 7 -> mode_led=1, addr_led=0, request with rd_sel=1, rd_addr=0; refresh re-issues the same request every 64 cycles.

Source files
------------

// File: rtl/debug_view.sv
// debug_view: button-driven viewer for the register file / data memory.
// Debounced address/mode controls feed a single-outstanding read port.
module debug_view #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REFRESH_CYCLES  = 5000000,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_mode,
  output logic        rd_req,
  output logic        rd_sel,
  output logic [7:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic [31:0] data_display,
  output logic [7:0]  addr_led,
  output logic        mode_led
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // bit 0 = inc, bit 1 = dec, bit 2 = mode
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    prev_q, prev_d;
  logic [2:0]    ev;
  logic [DW-1:0] dbc_q [3];
  logic [DW-1:0] dbc_d [3];

  logic [7:0]    addr_q, addr_d;
  logic          mode_q, mode_d;
  logic [7:0]    addr_inc, addr_dec;
  logic          set_pend;
  logic          pend_q, pend_d;

  logic [RW-1:0] ref_q, ref_d;
  logic          ref_wrap;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          to_hit;
  logic          issue;
  logic          req_q, req_d;
  logic          sel_q, sel_d;
  logic [7:0]    raddr_q, raddr_d;
  logic [31:0]   disp_q, disp_d;

  assign btn_raw = {btn_mode, btn_dec, btn_inc};

  // Two-flop synchronizer on the raw buttons
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES differing samples
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of a debounced level is a one-cycle event
  always_comb begin
    prev_d = deb_q;
    ev     = deb_q & ~prev_q;
  end

  // Wrapped address steps; register view stays within 0..31
  always_comb begin
    if (mode_q) begin
      addr_inc = addr_q + 8'd1;
      addr_dec = addr_q - 8'd1;
    end else begin
      addr_inc = {3'b000, addr_q[4:0] + 5'd1};
      addr_dec = {3'b000, addr_q[4:0] - 5'd1};
    end
  end

  // View registers: mode wins, inc+dec together cancel
  always_comb begin
    addr_d   = addr_q;
    mode_d   = mode_q;
    set_pend = 1'b0;
    unique case (1'b1)
      ev[2]: begin
        mode_d   = ~mode_q;
        addr_d   = '0;
        set_pend = 1'b1;
      end
      ev[0] & ~ev[1] & ~ev[2]: begin
        addr_d   = addr_inc;
        set_pend = 1'b1;
      end
      ev[1] & ~ev[0] & ~ev[2]: begin
        addr_d   = addr_dec;
        set_pend = 1'b1;
      end
      default: ;
    endcase
  end

  // Free-running refresh counter
  always_comb begin
    ref_wrap = (ref_q == RF_LAST);
    ref_d    = ref_wrap ? '0 : ref_q + 1'b1;
  end

  // Pending read: new setters win over the clear on issue
  always_comb begin
    issue  = (state_q == S_IDLE) & pend_q;
    pend_d = set_pend | ref_wrap | (pend_q & ~issue);
  end

  // FSM next state
  always_comb begin
    to_hit  = (tcnt_q == TO_LAST);
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pend_q) state_d = S_WAIT;
      S_WAIT: if (rd_ack || to_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: latch request, capture data or timeout marker
  always_comb begin
    req_d   = req_q;
    sel_d   = sel_q;
    raddr_d = raddr_q;
    disp_d  = disp_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          req_d   = 1'b1;
          raddr_d = addr_q;
          sel_d   = mode_q;
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (rd_ack) begin
          disp_d = rd_data;
          req_d  = 1'b0;
        end else if (to_hit) begin
          disp_d = 32'hFFFF_FFFF;
          req_d  = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: req_d = 1'b0;
    endcase
  end

  // Button front-end state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 3; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      for (int i = 0; i < 3; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  // View, pending and refresh state; first read issues right after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      mode_q <= 1'b0;
      pend_q <= 1'b1;
      ref_q  <= '0;
    end else begin
      addr_q <= addr_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      ref_q  <= ref_d;
    end
  end

  // Read port state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      sel_q   <= 1'b0;
      raddr_q <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      raddr_q <= raddr_d;
      disp_q  <= disp_d;
    end
  end

  assign rd_req       = req_q;
  assign rd_sel       = sel_q;
  assign rd_addr      = raddr_q;
  assign data_display = disp_q;
  assign addr_led     = addr_q;
  assign mode_led     = mode_q;

endmodule

// File: tb/tb_debug_view.sv
// tb_debug_view: scoreboard bench for debug_view.
// Button model and read responder drive; monitor checks completed reads.
module tb_debug_view;
  localparam int DB = 4;
  localparam int RF = 64;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  btns = 3'b000;
  logic        rd_req, rd_sel, rd_ack;
  logic [7:0]  rd_addr, addr_led;
  logic [31:0] rd_data, data_display;
  logic        mode_led;

  logic        ack_main = 1'b0;
  logic        ack_resp = 1'b0;
  logic [31:0] data_main = '0;
  logic [31:0] data_resp = '0;

  assign rd_ack  = ack_main | ack_resp;
  assign rd_data = ack_main ? data_main : data_resp;

  debug_view #(
    .DEBOUNCE_CYCLES(DB),
    .REFRESH_CYCLES(RF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_inc(btns[0]),
    .btn_dec(btns[1]),
    .btn_mode(btns[2]),
    .rd_req(rd_req),
    .rd_sel(rd_sel),
    .rd_addr(rd_addr),
    .rd_ack(rd_ack),
    .rd_data(rd_data),
    .data_display(data_display),
    .addr_led(addr_led),
    .mode_led(mode_led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  // reference view: current and pre-press values
  int m_addr = 0;
  int m_mode = 0;
  int p_addr = 0;
  int p_mode = 0;
  bit window = 0;
  bit seen_new = 0;
  bit auto_ack = 0;
  bit resp_busy = 0;
  bit noack_next = 0;
  int n_timeouts = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // responder: acks after a random delay or lets the read time out
  always begin : responder
    int d, n;
    bit hit;
    logic [31:0] v;
    @(negedge clk);
    if (auto_ack && !rst && rd_req && !resp_busy) begin
      resp_busy = 1;
      hit = (rd_addr == m_addr[7:0]) && (rd_sel == m_mode[0]);
      if (window && hit) seen_new = 1;
      if (window && rd_addr == p_addr[7:0] && rd_sel == p_mode[0]) hit = 1;
      chk("req_view", {rd_sel, rd_addr}, hit ? {rd_sel, rd_addr} : {m_mode[0], m_addr[7:0]});
      if (noack_next || $urandom_range(0, 5) == 0) begin
        noack_next = 0;
        exp_q.push_back(32'hFFFF_FFFF);
        n = 1;
        while (n < 40) begin
          @(negedge clk);
          if (!rd_req) break;
          n++;
        end
        chk("timeout_len", n, TO);
        n_timeouts++;
      end else begin
        d = $urandom_range(1, 5);
        v = $urandom;
        exp_q.push_back(v);
        repeat (d - 1) @(negedge clk);
        ack_resp = 1;
        data_resp = v;
        @(negedge clk);
        ack_resp = 0;
        chk("req_drop", rd_req, 0);
      end
      resp_busy = 0;
    end
  end

  // monitor: every completed read must show the scoreboard value
  bit prev_req = 0;
  always begin : monitor
    @(negedge clk);
    if (rst) begin
      prev_req = 0;
    end else begin
      if (prev_req && !rd_req) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL display: read ended with nothing expected, got %h",
                   data_display);
        end else begin
          chk("display", data_display, exp_q.pop_front());
        end
      end
      prev_req = rd_req;
    end
  end

  // press buttons in mask {mode,dec,inc} for hold cycles, then settle
  task automatic press(input logic [2:0] mask, input int hold);
    bit changed;
    p_addr = m_addr;
    p_mode = m_mode;
    seen_new = 0;
    window = 1;
    if (hold >= 8) begin
      if (mask[2]) begin
        m_mode = 1 - m_mode;
        m_addr = 0;
      end else if (mask[0] && !mask[1]) begin
        m_addr = m_mode ? (m_addr + 1) % 256 : (m_addr + 1) % 32;
      end else if (mask[1] && !mask[0]) begin
        m_addr = m_mode ? (m_addr + 255) % 256 : (m_addr + 31) % 32;
      end
    end
    changed = (m_addr != p_addr) || (m_mode != p_mode);
    @(negedge clk);
    btns = mask;
    repeat (hold) @(negedge clk);
    btns = 3'b000;
    repeat (40) @(negedge clk);
    window = 0;
    chk("addr_led", addr_led, m_addr);
    chk("mode_led", mode_led, m_mode);
    if (changed) chk("new_read", seen_new, 1);
  endtask

  task automatic go_manual();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (!resp_busy && !rd_req) break;
    end
    if (k == 200) expired("go_manual");
    auto_ack = 0;
  endtask

  task automatic wait_level(input string name, input logic lvl);
    int k;
    for (k = 0; k < 150; k++) begin
      @(negedge clk);
      if (rd_req == lvl) break;
    end
    if (k == 150) expired(name);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, t1, t2, tn;
    logic [31:0] v;
    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_req", rd_req, 0);
    chk("rst_sel", rd_sel, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_disp", data_display, 0);
    chk("rst_aled", addr_led, 0);
    chk("rst_mled", mode_led, 0);
    rst = 0;
    @(negedge clk);
    chk("first_req", rd_req, 1);
    chk("first_addr", rd_addr, 0);
    chk("first_sel", rd_sel, 0);
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h1234_5678);
    ack_main = 1;
    data_main = 32'h1234_5678;
    @(negedge clk);
    ack_main = 0;
    chk("first_drop", rd_req, 0);
    chk("first_disp", data_display, 32'h1234_5678);
    // spurious ack while idle
    ack_main = 1;
    data_main = 32'hDEAD_BEEF;
    @(negedge clk);
    ack_main = 0;
    @(negedge clk);
    chk("idle_ack", data_display, 32'h1234_5678);
    auto_ack = 1;

    press(3'b010, 12);
    press(3'b001, 12);
    press(3'b001, 2);
    press(3'b001, 20);
    press(3'b001, 12);
    press(3'b001, 12);

    // inc during an outstanding read at address 3
    go_manual();
    wait_level("wait_req3", 1);
    chk("wait_addr", rd_addr, 3);
    btns = 3'b001;
    m_addr = 4;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("wait_req_hold", rd_req, 1);
      chk("wait_addr_hold", rd_addr, 3);
      if (addr_led == 8'd4) break;
    end
    if (k == 10) expired("wait_inc_event");
    v = $urandom;
    exp_q.push_back(v);
    ack_main = 1;
    data_main = v;
    @(negedge clk);
    ack_main = 0;
    btns = 3'b000;
    chk("gap_idle", rd_req, 0);
    @(negedge clk);
    chk("b2b_req", rd_req, 1);
    chk("b2b_addr", rd_addr, 4);
    v = $urandom;
    exp_q.push_back(v);
    ack_main = 1;
    data_main = v;
    @(negedge clk);
    ack_main = 0;
    auto_ack = 1;
    repeat (20) @(negedge clk);

    // forced timeout
    tn = n_timeouts;
    noack_next = 1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (n_timeouts != tn) break;
    end
    if (k == 200) expired("timeout_wait");
    chk("timeout_disp", data_display, 32'hFFFF_FFFF);

    press(3'b001, 12);
    press(3'b001, 12);
    press(3'b001, 12);
    press(3'b100, 15);
    wait_level("ref_rise1", 1);
    t1 = cyc;
    chk("ref_addr", rd_addr, 0);
    chk("ref_sel", rd_sel, 1);
    wait_level("ref_fall", 0);
    wait_level("ref_rise2", 1);
    t2 = cyc;
    chk("ref_period", t2 - t1, RF);

    press(3'b010, 12);
    press(3'b001, 12);
    press(3'b001, 12);
    press(3'b011, 12);
    press(3'b101, 12);

    for (int i = 0; i < 20; i++) begin
      int h;
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2)
                                      : $urandom_range(8, 20);
      press(3'($urandom_range(1, 7)), h);
    end

    // reset while a read is outstanding
    go_manual();
    wait_level("rst_wait_req", 1);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    m_addr = 0;
    m_mode = 0;
    chk("arst_req", rd_req, 0);
    chk("arst_addr", rd_addr, 0);
    chk("arst_sel", rd_sel, 0);
    chk("arst_disp", data_display, 0);
    chk("arst_aled", addr_led, 0);
    chk("arst_mled", mode_led, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    ack_main = 1;
    data_main = 32'hCAFE_F00D;
    @(negedge clk);
    ack_main = 0;
    chk("post_req", rd_req, 1);
    chk("post_addr", rd_addr, 0);
    chk("late_ack", data_display, 0);
    exp_q.push_back(32'h0BAD_C0DE);
    ack_main = 1;
    data_main = 32'h0BAD_C0DE;
    @(negedge clk);
    ack_main = 0;
    chk("post_drop", rd_req, 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
